// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencing and HI/LO holding stage:
// FSM state encoding, operation/read selectors and default watchdog limits.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_MULT = 2'd1,
    ST_RUN_DIV  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned CNT_W_DEF          = 7;
  localparam int unsigned DATA_W             = 32;

endpackage

// File: rtl/muldiv_hilo_if.sv
// Bundle between the control unit / mult / div units and the HI/LO stage.
// master: control-unit and unit side (drives requests and unit results).
// slave : muldiv_hilo (drives unit enables, registers and status).
interface muldiv_hilo_if;
  import muldiv_pkg::*;

  logic              op_start;
  logic              op_sel;
  logic              mult_ctrl;
  logic [DATA_W-1:0] mult_hi;
  logic [DATA_W-1:0] mult_lo;
  logic              mult_stop;
  logic              div_ctrl;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;
  logic              div_stop;
  logic              div_zero;
  logic              mthi_we;
  logic              mtlo_we;
  logic [DATA_W-1:0] wr_data;
  logic              rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic              busy;
  logic              div0_exc;
  logic              timeout_err;

  modport master (
    output op_start, op_sel, mult_hi, mult_lo, mult_stop,
           div_hi, div_lo, div_stop, div_zero,
           mthi_we, mtlo_we, wr_data, rd_sel,
    input  mult_ctrl, div_ctrl, rd_data, HI, LO, busy, div0_exc, timeout_err
  );

  modport slave (
    input  op_start, op_sel, mult_hi, mult_lo, mult_stop,
           div_hi, div_lo, div_stop, div_zero,
           mthi_we, mtlo_we, wr_data, rd_sel,
    output mult_ctrl, div_ctrl, rd_data, HI, LO, busy, div0_exc, timeout_err
  );

endinterface

// File: rtl/op_watchdog.sv
// Cycle watchdog for a running operation.
// Ports: clk, reset (sync, active-high), clear (zero the count),
//        enable (count this cycle), expired (registered, high once the
//        count has reached TIMEOUT_CYCLES).
module op_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic             expired_q;

  // expired is asserted on the same edge the count reaches the limit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else if (enable) begin
      cnt_q     <= cnt_q + CNT_W'(1);
      expired_q <= ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
    end else begin
      expired_q <= 1'b0;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/muldiv_hilo.sv
// Sequences one mult/div operation at a time and holds the architectural
// HI/LO registers.
// Ports: clk, reset (sync, active-high), bus (muldiv_hilo_if.slave):
//   op_start/op_sel launch, *_ctrl level enables to the units, *_stop/*_hi/
//   *_lo unit results, mthi/mtlo writes, rd_sel/rd_data read mux, busy,
//   div0_exc and timeout_err one-cycle pulses during DONE.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input logic           clk,
  input logic           reset,
  muldiv_hilo_if.slave  bus
);

  state_e            state_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              mult_ctrl_q;
  logic              div_ctrl_q;
  logic              busy_q;
  logic              div0_q;
  logic              tmo_q;
  logic              wd_expired;

  op_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_IDLE),
    .enable  ((state_q == ST_RUN_MULT) || (state_q == ST_RUN_DIV)),
    .expired (wd_expired)
  );

  // FSM, unit enables, status pulses and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      mult_ctrl_q <= 1'b0;
      div_ctrl_q  <= 1'b0;
      busy_q      <= 1'b0;
      div0_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      div0_q <= 1'b0;
      tmo_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // a write in the launch cycle lands first; the result overwrites it
          if (bus.mthi_we) hi_q <= bus.wr_data;
          if (bus.mtlo_we) lo_q <= bus.wr_data;
          if (bus.op_start) begin
            state_q     <= (bus.op_sel == OP_DIV) ? ST_RUN_DIV : ST_RUN_MULT;
            mult_ctrl_q <= (bus.op_sel != OP_DIV);
            div_ctrl_q  <= (bus.op_sel == OP_DIV);
            busy_q      <= 1'b1;
          end
        end
        ST_RUN_MULT: begin
          if (bus.mult_stop) begin
            hi_q        <= bus.mult_hi;
            lo_q        <= bus.mult_lo;
            state_q     <= ST_DONE;
            mult_ctrl_q <= 1'b0;
          end else if (wd_expired) begin
            tmo_q       <= 1'b1;
            state_q     <= ST_DONE;
            mult_ctrl_q <= 1'b0;
          end
        end
        ST_RUN_DIV: begin
          if (bus.div_stop) begin
            if (bus.div_zero) begin
              div0_q <= 1'b1;
            end else begin
              hi_q <= bus.div_hi;
              lo_q <= bus.div_lo;
            end
            state_q    <= ST_DONE;
            div_ctrl_q <= 1'b0;
          end else if (wd_expired) begin
            tmo_q      <= 1'b1;
            state_q    <= ST_DONE;
            div_ctrl_q <= 1'b0;
          end
        end
        ST_DONE: begin
          // one guaranteed low cycle on ctrl so the unit reinitialises
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          mult_ctrl_q <= 1'b0;
          div_ctrl_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mult_ctrl   = mult_ctrl_q;
  assign bus.div_ctrl    = div_ctrl_q;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.div0_exc    = div0_q;
  assign bus.timeout_err = tmo_q;
  assign bus.rd_data     = (bus.rd_sel == RD_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo.
module tb_muldiv_hilo;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  muldiv_hilo_if bus ();

  muldiv_hilo #(
    .TIMEOUT_CYCLES (64),
    .CNT_W          (7)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs are driven and outputs sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset        = 1'b1;
    bus.op_start = 1'b0;
    bus.op_sel   = 1'b0;
    bus.mult_hi  = '0;
    bus.mult_lo  = '0;
    bus.mult_stop = 1'b0;
    bus.div_hi   = '0;
    bus.div_lo   = '0;
    bus.div_stop = 1'b0;
    bus.div_zero = 1'b0;
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b0;
    bus.wr_data  = '0;
    bus.rd_sel   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_mctrl", 32'(bus.mult_ctrl), 32'd0);
    check("rst_dctrl", 32'(bus.div_ctrl), 32'd0);
    check("rst_tmo", 32'(bus.timeout_err), 32'd0);

    // 6 x 7 with a 33-cycle mult
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.op_start = 1'b0;
    check("m1_busy", 32'(bus.busy), 32'd1);
    check("m1_mctrl", 32'(bus.mult_ctrl), 32'd1);
    check("m1_dctrl", 32'(bus.div_ctrl), 32'd0);
    repeat (32) tick();
    check("m1_busy_run", 32'(bus.busy), 32'd1);
    bus.mult_stop = 1'b1;
    bus.mult_hi   = 32'd0;
    bus.mult_lo   = 32'd42;
    tick();
    bus.mult_stop = 1'b0;
    check("m1_hi", bus.HI, 32'd0);
    check("m1_lo", bus.LO, 32'd42);
    check("m1_done_busy", 32'(bus.busy), 32'd1);
    check("m1_done_mctrl", 32'(bus.mult_ctrl), 32'd0);
    tick();
    check("m1_idle_busy", 32'(bus.busy), 32'd0);

    // 100000 x 100000
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.op_start = 1'b0;
    repeat (4) tick();
    bus.mult_stop = 1'b1;
    bus.mult_hi   = 32'h0000_0002;
    bus.mult_lo   = 32'h540B_E400;
    tick();
    bus.mult_stop = 1'b0;
    tick();
    check("m2_hi", bus.HI, 32'h0000_0002);
    check("m2_lo", bus.LO, 32'h540B_E400);
    bus.rd_sel = 1'b1;
    #1;
    check("m2_rd_hi", bus.rd_data, 32'd2);
    bus.rd_sel = 1'b0;
    #1;
    check("m2_rd_lo", bus.rd_data, 32'h540B_E400);

    // 42 / 5, with a stray mult_stop that must be ignored
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b1;
    tick();
    bus.op_start = 1'b0;
    check("d1_dctrl", 32'(bus.div_ctrl), 32'd1);
    check("d1_mctrl", 32'(bus.mult_ctrl), 32'd0);
    bus.mult_stop = 1'b1;
    bus.mult_hi   = 32'hAAAA_AAAA;
    bus.mult_lo   = 32'h5555_5555;
    tick();
    bus.mult_stop = 1'b0;
    check("d1_stray_busy", 32'(bus.busy), 32'd1);
    check("d1_stray_hi", bus.HI, 32'd2);
    repeat (3) tick();
    bus.div_stop = 1'b1;
    bus.div_hi   = 32'd2;
    bus.div_lo   = 32'd8;
    tick();
    bus.div_stop = 1'b0;
    check("d1_hi", bus.HI, 32'd2);
    check("d1_lo", bus.LO, 32'd8);
    check("d1_done_dctrl", 32'(bus.div_ctrl), 32'd0);
    check("d1_done_busy", 32'(bus.busy), 32'd1);
    tick();
    check("d1_idle_busy", 32'(bus.busy), 32'd0);

    // divide by zero keeps HI/LO and pulses div0_exc for one cycle
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b1;
    tick();
    bus.op_start = 1'b0;
    tick();
    check("z_div0_early", 32'(bus.div0_exc), 32'd0);
    bus.div_stop = 1'b1;
    bus.div_zero = 1'b1;
    bus.div_hi   = 32'hFFFF_FFFF;
    bus.div_lo   = 32'hFFFF_FFFF;
    tick();
    bus.div_stop = 1'b0;
    bus.div_zero = 1'b0;
    check("z_div0", 32'(bus.div0_exc), 32'd1);
    check("z_hi", bus.HI, 32'd2);
    check("z_lo", bus.LO, 32'd8);
    tick();
    check("z_div0_end", 32'(bus.div0_exc), 32'd0);
    check("z_busy", 32'(bus.busy), 32'd0);

    // stuck stop: timeout pulse 65 edges after the launch edge
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.op_start = 1'b0;
    repeat (64) tick();
    check("t_pre_tmo", 32'(bus.timeout_err), 32'd0);
    check("t_pre_busy", 32'(bus.mult_ctrl), 32'd1);
    tick();
    check("t_tmo", 32'(bus.timeout_err), 32'd1);
    check("t_mctrl", 32'(bus.mult_ctrl), 32'd0);
    check("t_hi", bus.HI, 32'd2);
    check("t_lo", bus.LO, 32'd8);
    tick();
    check("t_tmo_end", 32'(bus.timeout_err), 32'd0);
    check("t_idle", 32'(bus.busy), 32'd0);

    // mthi while busy is ignored, then reset mid-RUN
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.op_start = 1'b0;
    bus.mthi_we  = 1'b1;
    bus.wr_data  = 32'hDEAD_BEEF;
    tick();
    bus.mthi_we  = 1'b0;
    check("w_busy_hi", bus.HI, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_busy", 32'(bus.busy), 32'd0);
    check("r_mctrl", 32'(bus.mult_ctrl), 32'd0);
    check("r_hi", bus.HI, 32'd0);
    check("r_lo", bus.LO, 32'd0);

    // late stop in IDLE is ignored
    bus.mult_stop = 1'b1;
    bus.mult_lo   = 32'd99;
    tick();
    bus.mult_stop = 1'b0;
    check("late_lo", bus.LO, 32'd0);
    check("late_busy", 32'(bus.busy), 32'd0);

    // mthi in IDLE
    bus.mthi_we = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.mthi_we = 1'b0;
    check("w_idle_hi", bus.HI, 32'hDEAD_BEEF);
    check("w_idle_lo", bus.LO, 32'd0);

    // both writes together
    bus.mthi_we = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.wr_data = 32'h1234_5678;
    tick();
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
    check("w_both_hi", bus.HI, 32'h1234_5678);
    check("w_both_lo", bus.LO, 32'h1234_5678);

    // write and launch together: write lands, result overwrites it
    bus.mtlo_we  = 1'b1;
    bus.wr_data  = 32'hCAFE_F00D;
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    tick();
    bus.mtlo_we  = 1'b0;
    bus.op_start = 1'b0;
    check("wl_lo", bus.LO, 32'hCAFE_F00D);
    check("wl_busy", 32'(bus.busy), 32'd1);
    bus.mult_stop = 1'b1;
    bus.mult_hi   = 32'd0;
    bus.mult_lo   = 32'd7;
    tick();
    bus.mult_stop = 1'b0;
    check("wl_res_lo", bus.LO, 32'd7);
    check("wl_res_hi", bus.HI, 32'd0);
    tick();
    check("wl_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
